// File: rtl/ula_multiciclo.sv
// ula_multiciclo: EX-stage execution unit. Logic and arithmetic ops finish in
// one cycle. Signed multiply and divide run iteratively on magnitudes and get
// their sign fixed in a final cycle. HI/LO hold the product, or the
// remainder/quotient, of the last completed mult/div.
//
// state   | meaning
// --------+----------------------------------------------------------------
// ST_IDLE | waiting for start; simple ops and div-by-zero complete from here
// ST_ITER | one shift-add (mult) or shift-subtract (div) step per cycle
// ST_FIX  | apply result signs, write hi/lo/result, pulse done
module ula_multiciclo #(
  parameter int WIDTH = 32,
  parameter int ITER  = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       opCode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             divByZero
);

  localparam int CW = $clog2(ITER + 1);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_OR  = 3'b010;
  localparam logic [2:0] OP_EQ  = 3'b011;
  localparam logic [2:0] OP_LT  = 3'b100;
  localparam logic [2:0] OP_MUL = 3'b101;
  localparam logic [2:0] OP_DIV = 3'b110;
  localparam logic [2:0] OP_AND = 3'b111;

  typedef enum logic [1:0] {ST_IDLE, ST_ITER, ST_FIX} state_t;

  state_t             state_q, state_d;
  // Mult: {partial product high, multiplier}. Div: {remainder, dividend/quotient}.
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               is_div_q, is_div_d;
  logic               neg_lo_q, neg_lo_d;
  logic               neg_hi_q, neg_hi_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               zero_q, zero_d;
  logic               done_q, done_d;
  logic               dbz_q, dbz_d;

  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     sum, shifted, diff;
  logic [2*WIDTH-1:0] prod;

  // Next-state, datapath step and result write-back
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    opb_d    = opb_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    result_d = result_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    dbz_d    = dbz_q;
    done_d   = 1'b0;
    a_mag    = a[WIDTH-1] ? -a : a;
    b_mag    = b[WIDTH-1] ? -b : b;
    sum      = '0;
    shifted  = '0;
    diff     = '0;
    prod     = '0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          dbz_d = 1'b0;
          cnt_d = CW'(ITER - 1);
          case (opCode)
            OP_ADD: begin result_d = a + b; done_d = 1'b1; end
            OP_SUB: begin result_d = a - b; done_d = 1'b1; end
            OP_OR:  begin result_d = a | b; done_d = 1'b1; end
            OP_AND: begin result_d = a & b; done_d = 1'b1; end
            OP_EQ: begin
              result_d = {{(WIDTH-1){1'b0}}, (a == b)};
              done_d   = 1'b1;
            end
            OP_LT: begin
              result_d = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
              done_d   = 1'b1;
            end
            OP_MUL: begin
              state_d  = ST_ITER;
              is_div_d = 1'b0;
              acc_d    = {{WIDTH{1'b0}}, b_mag};
              opb_d    = a_mag;
              neg_lo_d = a[WIDTH-1] ^ b[WIDTH-1];
              neg_hi_d = a[WIDTH-1] ^ b[WIDTH-1];
            end
            OP_DIV: begin
              if (b == '0) begin
                // hi/lo keep their old contents; only the flag and result change
                result_d = '0;
                dbz_d    = 1'b1;
                done_d   = 1'b1;
              end else begin
                state_d  = ST_ITER;
                is_div_d = 1'b1;
                acc_d    = {{WIDTH{1'b0}}, a_mag};
                opb_d    = b_mag;
                neg_lo_d = a[WIDTH-1] ^ b[WIDTH-1];
                neg_hi_d = a[WIDTH-1];
              end
            end
            default: ;
          endcase
        end
      end

      ST_ITER: begin
        if (is_div_q) begin
          // Restoring step: bring in next dividend bit, subtract if it fits
          shifted = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
          diff    = shifted - {1'b0, opb_q};
          if (!diff[WIDTH])
            acc_d = {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
          else
            acc_d = {shifted[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end else begin
          // Shift-add step: carry out of the add lands in the top bit
          sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
          acc_d = {sum, acc_q[WIDTH-1:1]};
        end
        if (cnt_q == '0) state_d = ST_FIX;
        else             cnt_d   = cnt_q - CW'(1);
      end

      ST_FIX: begin
        if (is_div_q) begin
          lo_d = neg_lo_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
          hi_d = neg_hi_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
        end else begin
          prod = neg_lo_q ? -acc_q : acc_q;
          hi_d = prod[2*WIDTH-1:WIDTH];
          lo_d = prod[WIDTH-1:0];
        end
        result_d = lo_d;
        done_d   = 1'b1;
        state_d  = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase

    zero_d = (result_d == '0);
  end

  // State and datapath registers; reset aborts any running operation
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      acc_q    <= '0;
      opb_q    <= '0;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      result_q <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      zero_q   <= 1'b1;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      opb_q    <= opb_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      result_q <= result_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      zero_q   <= zero_d;
      done_q   <= done_d;
      dbz_q    <= dbz_d;
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign result    = result_q;
  assign zero      = zero_q;
  assign done      = done_q;
  assign hi        = hi_q;
  assign lo        = lo_q;
  assign divByZero = dbz_q;

endmodule

// File: tb/tb_ula_multiciclo.sv
// Scoreboard bench for ula_multiciclo: the driver pushes hand-computed
// expectations as each op is accepted; the monitor pops one per done pulse.
module tb_ula_multiciclo;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_OR  = 3'b010;
  localparam logic [2:0] OP_EQ  = 3'b011;
  localparam logic [2:0] OP_LT  = 3'b100;
  localparam logic [2:0] OP_MUL = 3'b101;
  localparam logic [2:0] OP_DIV = 3'b110;
  localparam logic [2:0] OP_AND = 3'b111;

  // Clock edges from the accepting edge to the edge that raises done
  localparam int LAT_S = 0;
  localparam int LAT_L = 33;

  logic        clock, reset, start;
  logic [2:0]  opCode;
  logic [31:0] a_in, b_in;
  logic [31:0] result, hi, lo;
  logic        zero, busy, done, divByZero;

  ula_multiciclo #(.WIDTH(32), .ITER(32)) dut (
    .clock(clock), .reset(reset), .start(start), .opCode(opCode),
    .a(a_in), .b(b_in), .result(result), .zero(zero), .busy(busy),
    .done(done), .hi(hi), .lo(lo), .divByZero(divByZero)
  );

  typedef struct {
    string       name;
    logic [31:0] res;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
    int          acc_cyc;
    int          lat;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp_v);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clock) begin
    if (!reset && done) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_done: done=1 at cycle %0d with nothing outstanding", cyc);
      end else begin
        mon_e = sb.pop_front();
        chk({mon_e.name, "_result"}, result, mon_e.res);
        chk({mon_e.name, "_zero"}, {31'd0, zero}, {31'd0, (mon_e.res == 32'd0)});
        chk({mon_e.name, "_hi"}, hi, mon_e.hi);
        chk({mon_e.name, "_lo"}, lo, mon_e.lo);
        chk({mon_e.name, "_dbz"}, {31'd0, divByZero}, {31'd0, mon_e.dbz});
        chk({mon_e.name, "_latency"}, 32'(cyc - mon_e.acc_cyc), 32'(mon_e.lat));
      end
    end
  end

  task automatic push_exp(input string nm, input logic [31:0] er, input logic [31:0] eh,
                          input logic [31:0] el, input logic ed, input int lat);
    exp_t e;
    e.name = nm; e.res = er; e.hi = eh; e.lo = el; e.dbz = ed;
    e.acc_cyc = cyc; e.lat = lat;
    sb.push_back(e);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || sb.size() != 0) && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (n >= 200) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wait_idle: timeout busy=%0d outstanding=%0d", busy, sb.size());
      sb.delete();
    end
  endtask

  task automatic issue(input string nm, input logic [2:0] op, input logic [31:0] av,
                       input logic [31:0] bv, input logic [31:0] er, input logic [31:0] eh,
                       input logic [31:0] el, input logic ed, input int lat);
    wait_idle();
    @(negedge clock);
    start = 1'b1; opCode = op; a_in = av; b_in = bv;
    @(posedge clock);
    #1;
    push_exp(nm, er, eh, el, ed, lat);
    start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset = 1'b1; start = 1'b0; opCode = OP_ADD; a_in = '0; b_in = '0;
    repeat (2) @(negedge clock);
    chk("rst_result", result, 32'd0);
    chk("rst_zero", {31'd0, zero}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_dbz", {31'd0, divByZero}, 32'd0);
    reset = 1'b0;

    // Reset in the middle of a multiply: no done may follow
    @(negedge clock);
    start = 1'b1; opCode = OP_MUL; a_in = 32'd3; b_in = 32'd5;
    @(posedge clock);
    #1 start = 1'b0;
    repeat (9) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    #1;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_result", result, 32'd0);
    chk("midrst_hi", hi, 32'd0);
    chk("midrst_lo", lo, 32'd0);
    chk("midrst_zero", {31'd0, zero}, 32'd1);
    @(negedge clock);
    reset = 1'b0;
    repeat (40) @(negedge clock);

    issue("add_2_3",   OP_ADD, 32'd2,        32'd3,        32'd5,        0, 0, 0, LAT_S);
    issue("add_wrap",  OP_ADD, 32'hFFFFFFFF, 32'd1,        32'd0,        0, 0, 0, LAT_S);
    issue("sub_5_7",   OP_SUB, 32'd5,        32'd7,        32'hFFFFFFFE, 0, 0, 0, LAT_S);
    issue("lt_m1_1",   OP_LT,  32'hFFFFFFFF, 32'd1,        32'd1,        0, 0, 0, LAT_S);
    issue("lt_1_m1",   OP_LT,  32'd1,        32'hFFFFFFFF, 32'd0,        0, 0, 0, LAT_S);
    issue("eq_7_7",    OP_EQ,  32'd7,        32'd7,        32'd1,        0, 0, 0, LAT_S);
    issue("eq_7_8",    OP_EQ,  32'd7,        32'd8,        32'd0,        0, 0, 0, LAT_S);
    issue("or",        OP_OR,  32'h0000F0F0, 32'h00000FF0, 32'h0000FFF0, 0, 0, 0, LAT_S);
    issue("and",       OP_AND, 32'h0000F0F0, 32'h00000FF0, 32'h000000F0, 0, 0, 0, LAT_S);

    // -3 * 7 with a count of busy-high cycles after the accepting edge
    issue("mul_m3_7", OP_MUL, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFEB, 32'hFFFFFFFF, 32'hFFFFFFEB, 0, LAT_L);
    n = 0;
    @(negedge clock);
    while (busy && n < 100) begin
      n++;
      @(negedge clock);
    end
    chk("mul_busy_cycles", 32'(n), 32'd33);

    issue("mul_2p16",  OP_MUL, 32'h00010000, 32'h00010000, 32'd0,        32'd1, 32'd0,        0, LAT_L);
    issue("mul_lui",   OP_MUL, 32'h00001234, 32'd65536,    32'h12340000, 32'd0, 32'h12340000, 0, LAT_L);
    issue("div_m7_2",  OP_DIV, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFD, 0, LAT_L);
    issue("div_7_m2",  OP_DIV, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1,        32'hFFFFFFFD, 0, LAT_L);
    issue("div_min",   OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0,        32'h80000000, 0, LAT_L);
    issue("div_by_0",  OP_DIV, 32'd9,        32'd0,        32'd0,        32'd0,        32'h80000000, 1, LAT_S);
    issue("add_clr",   OP_ADD, 32'd1,        32'd1,        32'd2,        32'd0,        32'h80000000, 0, LAT_S);

    // Start pulsed during a divide is ignored
    issue("div_100_7", OP_DIV, 32'd100, 32'd7, 32'd14, 32'd2, 32'd14, 0, LAT_L);
    repeat (5) @(negedge clock);
    chk("ign_busy", {31'd0, busy}, 32'd1);
    start = 1'b1; opCode = OP_ADD; a_in = 32'd1; b_in = 32'd1;
    @(negedge clock);
    start = 1'b0;

    // Start held through the done cycle: accepted back-to-back
    issue("mul_2_3", OP_MUL, 32'd2, 32'd3, 32'd6, 32'd0, 32'd6, 0, LAT_L);
    start = 1'b1; opCode = OP_MUL; a_in = 32'd4; b_in = 32'd5;
    n = 0;
    while (!done && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (n >= 100) begin
      n_cmp++;
      n_bad++;
      $display("FAIL b2b_done: done never seen, waited %0d cycles", n);
    end
    @(posedge clock);
    #1;
    push_exp("mul_4_5", 32'd20, 32'd0, 32'd20, 0, LAT_L);
    start = 1'b0;
    chk("b2b_busy", {31'd0, busy}, 32'd1);

    // Operands wiggling after acceptance must not disturb the multiply
    issue("mul_6_7", OP_MUL, 32'd6, 32'd7, 32'd42, 32'd0, 32'd42, 0, LAT_L);
    repeat (20) begin
      @(negedge clock);
      a_in = $urandom;
      b_in = $urandom;
    end

    wait_idle();
    repeat (3) @(negedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
